// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's data-bus initiator (master) and a data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering RV32I loads/stores with programmable wait states,
// byte-lane writes, sign/zero-extending loads and access-error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_funct3;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          f_we;
  logic [31:0]   f_addr;
  logic [31:0]   f_wdata;
  logic [2:0]    f_funct3;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   merged;
  logic          acc_err;

  assign bus.req_ready = reset && (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  assign enter_resp    = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (cnt == 4'd1));

  // With zero wait states the response is computed at the accept edge itself,
  // so the live request fields feed the datapath while idle.
  always_comb begin
    if (state == IDLE) begin
      f_we     = bus.req_we;
      f_addr   = bus.req_addr;
      f_wdata  = bus.req_wdata;
      f_funct3 = bus.req_funct3;
    end else begin
      f_we     = cap_we;
      f_addr   = cap_addr;
      f_wdata  = cap_wdata;
      f_funct3 = cap_funct3;
    end
  end

  assign offset   = f_addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign lane     = offset[1:0];
  assign word     = mem[word_idx];
  assign shifted  = word >> {lane, 3'b000};
  assign wr_data  = f_wdata << {lane, 3'b000};

  always_comb begin
    acc_err = (offset >= SPAN);
    case (f_funct3)
      3'b000:  ;
      3'b001:  if (offset[0]) acc_err = 1'b1;
      3'b010:  if (offset[1:0] != 2'b00) acc_err = 1'b1;
      3'b100:  if (f_we) acc_err = 1'b1;
      3'b101:  if (f_we || offset[0]) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    case (f_funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    case (f_funct3[1:0])
      2'b00:   wr_be = 4'b0001 << lane;
      2'b01:   wr_be = lane[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
    merged = {wr_be[3] ? wr_data[31:24] : word[31:24],
              wr_be[2] ? wr_data[23:16] : word[23:16],
              wr_be[1] ? wr_data[15:8]  : word[15:8],
              wr_be[0] ? wr_data[7:0]   : word[7:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_funct3    <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[AW'(i)] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_we     <= bus.req_we;
          cap_addr   <= bus.req_addr;
          cap_wdata  <= bus.req_wdata;
          cap_funct3 <= bus.req_funct3;
          if (WAIT_CYCLES == 0) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (f_we && !acc_err) mem[word_idx] <= merged;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        bus.rsp_err   <= acc_err;
        bus.rsp_rdata <= (acc_err || f_we) ? '0 : load_val;
      end else begin
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states, one with a non-zero base)
// checked against a byte-addressed reference memory.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rv   [3];
  logic        rwe  [3];
  logic [31:0] raddr[3];
  logic [31:0] rwd  [3];
  logic [2:0]  rf3  [3];
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  erv;
  logic [31:0] rdat [3];

  logic [7:0] mb [3][256];
  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : u
    dmem_responder_if bus ();
    dmem_responder #(
      .DEPTH_WORDS(64),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .BASE_ADDR  (g == 2 ? 32'h1000_0000 : 32'h0000_0000)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
    );
    assign bus.req_valid  = rv[g];
    assign bus.req_we     = rwe[g];
    assign bus.req_addr   = raddr[g];
    assign bus.req_wdata  = rwd[g];
    assign bus.req_funct3 = rf3[g];
    assign rdy[g]  = bus.req_ready;
    assign vld[g]  = bus.rsp_valid;
    assign erv[g]  = bus.rsp_err;
    assign rdat[g] = bus.rsp_rdata;
  end

  function automatic int wcyc(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000_0000 : 32'h0000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) mb[d][i] = 8'h00;
  endtask

  // Reference: byte memory, access size 1/2/4 from funct3, alignment as a modulo test.
  function automatic void mdl_exec(input int d, input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   output logic [31:0] rd, output logic err);
    logic [31:0] off;
    int size;
    int o;
    bit legal;
    off   = addr - base_of(d);
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err   = !legal || (off >= 32'd256) || ((off % size) != 0);
    rd    = '0;
    if (!err) begin
      o = int'(off);
      if (we) begin
        for (int i = 0; i < size; i++) mb[d][o + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd = rd + (32'(mb[d][o + i]) << (8 * i));
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd - (32'd1 << (8 * size));
      end
    end
  endfunction

  task automatic do_req(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] exp_rd;
    logic exp_err;
    int n;
    rwe[d] = we; raddr[d] = addr; rwd[d] = wdata; rf3[d] = f3; rv[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
    check("accept_in_time", 32'(n < 20), 1);
    @(negedge clk);
    rv[d] = 1'b0;
    raddr[d] = $urandom; rwd[d] = $urandom; rf3[d] = 3'($urandom); rwe[d] = 1'($urandom);
    n = 1;
    while (!vld[d] && n < 30) begin @(negedge clk); n++; end
    check("latency", n, wcyc(d) + 1);
    check("ready_low_in_resp", rdy[d], 0);
    mdl_exec(d, we, addr, wdata, f3, exp_rd, exp_err);
    got = rdat[d];
    got_err = erv[d];
    check("rdata", rdat[d], exp_rd);
    check("err", erv[d], exp_err);
    @(negedge clk);
    check("valid_one_cycle", vld[d], 0);
    check("rdata_cleared", rdat[d], 0);
    check("err_cleared", erv[d], 0);
  endtask

  task automatic burst(input int d);
    int acc[$];
    int rsp[$];
    int cyc;
    bit drop;
    logic [31:0] exp_rd;
    logic exp_err;
    mdl_exec(d, 1'b0, base_of(d) + 32'h10, 32'h0, 3'b010, exp_rd, exp_err);
    rwe[d] = 1'b0; raddr[d] = base_of(d) + 32'h10; rf3[d] = 3'b010; rwd[d] = '0; rv[d] = 1'b1;
    cyc = 0;
    drop = 1'b0;
    while ((acc.size() < 3 || rsp.size() < 3) && cyc < 100) begin
      if (rv[d] && rdy[d]) begin
        acc.push_back(cyc);
        if (acc.size() == 3) drop = 1'b1;
      end
      if (vld[d]) begin
        rsp.push_back(cyc);
        check("b2b_ready_low", rdy[d], 0);
        check("b2b_rdata", rdat[d], exp_rd);
      end
      @(negedge clk);
      cyc++;
      if (drop) rv[d] = 1'b0;
    end
    check("b2b_accepts", acc.size(), 3);
    check("b2b_responses", rsp.size(), 3);
    for (int i = 0; i < acc.size() && i < rsp.size(); i++)
      check("b2b_latency", rsp[i] - acc[i], wcyc(d) + 1);
    for (int i = 1; i < acc.size(); i++)
      check("b2b_spacing", acc[i] - acc[i-1], wcyc(d) + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] g;
    logic e;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; raddr[d] = '0; rwd[d] = '0; rf3[d] = '0;
    end
    mdl_clear();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", rdy, 3'b000);
      check("reset_valid", vld, 3'b000);
      check("reset_err", erv, 3'b000);
      check("reset_rdata", rdat[1], 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", rdy, 3'b111);

    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, g, e);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, g, e); check("lw_10", g, 32'hDEADBEEF);
    do_req(1, 1'b0, 32'h13, 32'h0, 3'b000, g, e); check("lb_13", g, 32'hFFFFFFDE);
    do_req(1, 1'b0, 32'h13, 32'h0, 3'b100, g, e); check("lbu_13", g, 32'h000000DE);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b001, g, e); check("lh_10", g, 32'hFFFFBEEF);
    do_req(1, 1'b0, 32'h12, 32'h0, 3'b101, g, e); check("lhu_12", g, 32'h0000DEAD);
    do_req(1, 1'b1, 32'h11, 32'hFFFFFF55, 3'b000, g, e);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, g, e); check("lw_after_sb", g, 32'hDEAD55EF);
    do_req(1, 1'b1, 32'h12, 32'hABCD1234, 3'b001, g, e);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, g, e); check("lw_after_sh", g, 32'h123455EF);
    do_req(1, 1'b0, 32'h11, 32'h0, 3'b010, g, e); check("lw_misaligned_err", e, 1);
    do_req(1, 1'b1, 32'h13, 32'h0000FFFF, 3'b001, g, e); check("sh_misaligned_err", e, 1);
    do_req(1, 1'b0, 32'h100, 32'h0, 3'b010, g, e); check("lw_range_err", e, 1);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b011, g, e); check("funct3_err", e, 1);
    check("funct3_err_rdata", g, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, g, e); check("lw_unchanged", g, 32'h123455EF);

    do_req(0, 1'b1, 32'h10, 32'h0BADF00D, 3'b010, g, e);
    burst(0);
    do_req(2, 1'b1, 32'h1000_0010, 32'hC001D00D, 3'b010, g, e);
    burst(2);

    // Reset in the WAIT cycle must abort the store and suppress the response.
    rwe[1] = 1'b1; raddr[1] = 32'h20; rwd[1] = 32'hA5A5A5A5; rf3[1] = 3'b010; rv[1] = 1'b1;
    check("abort_ready_before", rdy[1], 1);
    @(negedge clk);
    rv[1] = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", vld[1], 0);
      check("abort_ready_low", rdy[1], 0);
    end
    rst = 1'b1;
    mdl_clear();
    @(negedge clk);
    check("abort_ready_after", rdy[1], 1);
    check("abort_no_valid_after", vld[1], 0);
    do_req(1, 1'b0, 32'h20, 32'h0, 3'b010, g, e); check("abort_lw_20", g, 0);

    for (int t = 0; t < 200; t++) begin
      int d;
      bit we;
      logic [2:0] f3;
      logic [31:0] off;
      d  = $urandom_range(0, 2);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end else begin
        f3 = 3'($urandom);
      end
      case ($urandom_range(0, 5))
        0:       off = 32'($urandom_range(240, 280));
        1:       off = $urandom;
        2:       off = 32'($urandom_range(0, 63));
        default: off = 32'($urandom_range(0, 63)) & ~32'(3);
      endcase
      do_req(d, we, base_of(d) + off, $urandom, f3, g, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
